// File: rtl/multicycle_datapath.sv
// Datapath slaved to the multicycle controller: load / transfer / add-or-subtract on two operands,
// with a registered result, a one-cycle valid strobe and a sticky protocol-error flag.
module multicycle_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             e,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             done,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             carry,
    output logic             proto_err
);

    logic [WIDTH-1:0] opa_q, opb_q, acc_q;
    logic             loaded;

    logic [WIDTH-1:0] acc_next;
    logic             cy;
    logic             do_load, do_exec, bad_step, viol, complete;

    // Carry is the unsigned carry-out for add and the unsigned borrow for subtract.
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic sub);
        if (sub)
            return {(x < y), x - y};
        else
            return {1'b0, x} + {1'b0, y};
    endfunction

    // Decode is nested so don't-care selects (possibly X) never reach state when e or s0 gates them off.
    always_comb begin
        acc_next = acc_q;
        cy       = 1'b0;
        do_load  = 1'b0;
        do_exec  = 1'b0;
        bad_step = 1'b0;
        if (e) begin
            if (!s0) begin
                do_load  = 1'b1;
                acc_next = '0;
            end else if ((s1 && s2) || !loaded) begin
                bad_step = 1'b1;
            end else begin
                do_exec = 1'b1;
                if (s1 || s2)
                    {cy, acc_next} = add_sub(acc_q, opb_q, s2);
                else
                    acc_next = opa_q;
            end
        end
    end

    always_comb begin
        viol     = e ? bad_step : done;
        complete = e && done && !bad_step;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opa_q        <= '0;
            opb_q        <= '0;
            acc_q        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            carry        <= 1'b0;
            proto_err    <= 1'b0;
            loaded       <= 1'b0;
        end else begin
            result_valid <= complete;
            if (do_load) begin
                opa_q <= a_in;
                opb_q <= b_in;
            end
            if (do_load || do_exec)
                acc_q <= acc_next;
            if (complete) begin
                result <= acc_next;
                carry  <= cy;
            end
            // A final step always ends the operation, even an illegal one.
            if (e && done)
                loaded <= 1'b0;
            else if (do_load)
                loaded <= 1'b1;
            if (viol)
                proto_err <= 1'b1;
            else if (err_clr)
                proto_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: expected {result, carry} pairs are queued when an
// operation is launched and popped whenever the datapath raises result_valid.
module tb_multicycle_datapath;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       e = 1'b0, s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, done = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       err_clr = 1'b0;
    logic [7:0] result;
    logic       result_valid, carry, proto_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    multicycle_datapath #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .e(e), .s0(s0), .s1(s1), .s2(s2), .done(done),
        .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
        .result(result), .result_valid(result_valid), .carry(carry), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one control word, clock it, then check the strobe and any result it delivers.
    task automatic step(input string tag, input logic ie, input logic is0, input logic is1,
                        input logic is2, input logic idone, input logic [7:0] a,
                        input logic [7:0] b, input logic exp_valid);
        logic [8:0] ex;
        e = ie; s0 = is0; s1 = is1; s2 = is2; done = idone; a_in = a; b_in = b;
        @(posedge clock);
        #1;
        chk({tag, "_valid"}, 32'(result_valid), 32'(exp_valid));
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected_result"}, 32'(exp_q.size()), 32'd1);
            end else begin
                ex = exp_q.pop_front();
                chk({tag, "_result"}, 32'(result), 32'(ex[7:0]));
                chk({tag, "_carry"}, 32'(carry), 32'(ex[8]));
            end
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'b0);
    endtask

    initial begin
        // Reset held with random activity, including enables and done
        for (int i = 0; i < 4; i++) begin
            e = 1'b1; s0 = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
            done = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
            err_clr = 1'($urandom);
            @(posedge clock);
        end
        #1;
        chk("rst_result", 32'(result), 32'h00);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_proto", 32'(proto_err), 32'd0);
        err_clr = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // 0x25 + 0x13, with X on the don't-care selects during load
        step("add_ld", 1, 0, 1'bx, 1'bx, 0, 8'h25, 8'h13, 0);
        step("add_tr", 1, 1, 0, 0, 0, 8'hxx, 8'hxx, 0);
        exp_q.push_back({1'b0, 8'h38});
        step("add_go", 1, 1, 1, 0, 1, 8'hxx, 8'hxx, 1);
        idle("add_after");
        chk("add_hold", 32'(result), 32'h38);

        // Add overflow
        step("ovf_ld", 1, 0, 0, 0, 0, 8'hF0, 8'h20, 0);
        step("ovf_tr", 1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        exp_q.push_back({1'b1, 8'h10});
        step("ovf_go", 1, 1, 1, 0, 1, 8'h00, 8'h00, 1);

        // Subtract with borrow
        step("sub_ld", 1, 0, 0, 0, 0, 8'h10, 8'h20, 0);
        step("sub_tr", 1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        exp_q.push_back({1'b1, 8'hF0});
        step("sub_go", 1, 1, 0, 1, 1, 8'h00, 8'h00, 1);
        chk("sub_proto", 32'(proto_err), 32'd0);

        // Illegal select holds the accumulator; err_clr recovers
        step("ill_ld", 1, 0, 0, 0, 0, 8'h05, 8'h01, 0);
        step("ill_tr", 1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        step("ill_sel", 1, 1, 1, 1, 0, 8'h00, 8'h00, 0);
        chk("ill_proto", 32'(proto_err), 32'd1);
        err_clr = 1'b1;
        idle("ill_clr");
        err_clr = 1'b0;
        chk("ill_cleared", 32'(proto_err), 32'd0);
        exp_q.push_back({1'b0, 8'h06});
        step("ill_add", 1, 1, 1, 0, 1, 8'h00, 8'h00, 1);

        // done with e=0, then violation beats a simultaneous err_clr
        step("done_noe", 0, 1'bx, 1'bx, 1'bx, 1, 8'h00, 8'h00, 0);
        chk("done_noe_proto", 32'(proto_err), 32'd1);
        chk("done_noe_result", 32'(result), 32'h06);
        err_clr = 1'b1;
        step("clr_vs_viol", 0, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        chk("clr_vs_viol_proto", 32'(proto_err), 32'd1);
        idle("clr2");
        err_clr = 1'b0;
        chk("clr2_proto", 32'(proto_err), 32'd0);

        // Asynchronous reset mid-operation, then execute without a load
        step("rst_ld", 1, 0, 0, 0, 0, 8'h03, 8'h04, 0);
        step("rst_tr", 1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_result", 32'(result), 32'h00);
        #1 reset = 1'b1;
        step("noload_add", 1, 1, 1, 0, 1, 8'h00, 8'h00, 0);
        chk("noload_proto", 32'(proto_err), 32'd1);
        chk("noload_result", 32'(result), 32'h00);
        err_clr = 1'b1;
        idle("clr3");
        err_clr = 1'b0;

        // Back-to-back: 0x01+0x02, then immediate load 0x07/0x01 and subtract
        step("b2b_ld1", 1, 0, 0, 0, 0, 8'h01, 8'h02, 0);
        step("b2b_tr1", 1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        exp_q.push_back({1'b0, 8'h03});
        step("b2b_go1", 1, 1, 1, 0, 1, 8'h00, 8'h00, 1);
        step("b2b_ld2", 1, 0, 0, 0, 0, 8'h07, 8'h01, 0);
        step("b2b_tr2", 1, 1, 0, 0, 0, 8'h00, 8'h00, 0);
        exp_q.push_back({1'b0, 8'h06});
        step("b2b_go2", 1, 1, 0, 1, 1, 8'h00, 8'h00, 1);
        idle("b2b_after");
        chk("b2b_proto", 32'(proto_err), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
